if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
- Two-entry fetch-to-decode skid buffer. It sits directly downstream of the PC register and instruction memory, and directly upstream of the decode stage.
- Captures {pc, instr} pairs from fetch and presents them to decode with a valid/ready handshake.
- Its if_ready output drives the PC register's PC_EN, so decode stalls back-pressure the PC cleanly.
- A flush input discards everything in flight, for branch/exception redirect.

Parameters:
- DATA_W, 32, instruction and PC width in bits
- RESET_PC, 32'h00003000, PC value presented on id_pc while the buffer is empty or in reset
- NOP_INSTR, 32'h00000000, instruction word presented on id_instr while the buffer is empty or in reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- if_valid  input  1  fetch offers a {pc, instr} pair this cycle
- if_pc  input  DATA_W  PC of the offered instruction
- if_instr  input  DATA_W  instruction word read from instruction memory
- if_ready  output  1  buffer accepts this cycle; wired to PC_EN
- flush  input  1  discard all held entries and the current offer
- id_ready  input  1  decode consumes the head entry this cycle
- id_valid  output  1  head entry is valid
- id_pc  output  DATA_W  head PC
- id_pc8  output  DATA_W  head PC + 8 (jal/jalr link value), modulo 2^DATA_W
- id_instr  output  DATA_W  head instruction
- count  output  2  occupancy, 0..2

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted: count=0, id_valid=0, id_pc=RESET_PC, id_pc8=RESET_PC+8, id_instr=NOP_INSTR, if_ready=1. Both storage entries are cleared to {RESET_PC, NOP_INSTR}.
- if_ready = (count != 2). It is combinational from registered count only; it does not depend on id_ready in the same cycle, so there is no combinational path from decode to PC.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & id_ready & ~flush.
- id_valid = (count != 0). id_pc, id_instr and id_pc8 come from the registered head entry; id_pc8 is a registered adder, not combinational output logic.
- Latency: one cycle. An entry pushed at edge N is visible on id_* after edge N. There is no same-cycle bypass.
- Ordering is strict FIFO. Head is entry 0 and tail is entry 1; on pop, entry 1 shifts into entry 0.
- Count transitions:
  - 0 with push: 1, head = incoming.
  - 1 with push and no pop: 2, tail = incoming.
  - 1 with push and pop: stays 1, head = incoming.
  - 1 with pop only: 0.
  - 2 with pop: 1, head = old tail. Push is impossible because if_ready=0.
  - Otherwise: hold.
- Empty state: id_pc, id_pc8 and id_instr show {RESET_PC, RESET_PC+8, NOP_INSTR}, so decode sees a nop.
- Full with id_ready=0: all state holds and if_ready=0, so the PC holds.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next state is count=0 with entries cleared as in reset; the offered pair is dropped.
  - if_ready after a flush is 1.
  - The redirect target PC is loaded by the PC register itself, not by this block.
- Reset mid-operation clears state immediately, without waiting for the clock edge. On release, the first push is accepted at the first rising edge.
- Wrap-around: id_pc8 for if_pc=32'hFFFFFFFC is 32'h00000004. No overflow flag.

Decomposition:
- Shared package constants: RESET_PC (32'h00003000), NOP_INSTR, PC_LINK_OFFSET (8). These are the same constants the PC register and the next-PC logic use.
- No sub-module. The two entries are plain registers inside this block; a generic FIFO is not warranted at depth 2.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with count=2 -> immediately count=0, id_valid=0, id_pc=32'h00003000, id_pc8=32'h00003008, id_instr=0, if_ready=1.
- Streaming: id_ready=1; push pc 0x3000/0x3004/0x3008 on consecutive cycles -> id_pc follows one cycle later in order, count stays 1, if_ready stays 1.
- Stall fill: id_ready=0; push 0x3000 then 0x3004 -> count=2, if_ready=0. Third offer 0x3008 is not accepted and the PC must hold.
- Drain: from full, raise id_ready -> id_pc 0x3000 then 0x3004, count 2→1→0, if_ready=1 after the first pop.
- Flush priority: count=2, assert flush together with if_valid (pc 0x4000) and id_ready -> next cycle count=0, id_valid=0, 0x4000 dropped.
- Link/wrap: push if_pc=32'hFFFFFFFC -> id_pc8=32'h00000004. Push if_pc=0x3010 -> id_pc8=0x3018.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - constants shared by PC register, next-PC logic and the fetch/decode buffer
`timescale 1ns/1ps
package if_id_buffer_pkg;

    localparam logic [31:0] RESET_PC       = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

    // Encoding doubles as the occupancy count driven to decode.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - two-entry fetch-to-decode skid buffer with flush
`timescale 1ns/1ps
module if_id_buffer #(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = DATA_W'(if_id_buffer_pkg::RESET_PC),
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(if_id_buffer_pkg::NOP_INSTR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_instr,
    output logic              if_ready,
    input  logic              flush,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_pc8,
    output logic [DATA_W-1:0] id_instr,
    output logic [1:0]        count
);
    import if_id_buffer_pkg::*;

    localparam logic [DATA_W-1:0] LINK_OFFSET = DATA_W'(PC_LINK_OFFSET);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc8;
        logic [DATA_W-1:0] instr;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{
        pc:    RESET_PC,
        pc8:   RESET_PC + LINK_OFFSET,
        instr: NOP_INSTR
    };

    occ_t   occ, occ_next;
    entry_t head, head_next;
    entry_t tail, tail_next;
    entry_t incoming;
    logic   push, pop;

    // Link value is added before the register so id_pc8 is a flop output.
    assign incoming = '{pc: if_pc, pc8: if_pc + LINK_OFFSET, instr: if_instr};

    // Ready depends only on registered occupancy: no decode-to-PC_EN path.
    assign if_ready = (occ != OCC_FULL);
    assign id_valid = (occ != OCC_EMPTY);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;

    assign id_pc    = head.pc;
    assign id_pc8   = head.pc8;
    assign id_instr = head.instr;
    assign count    = occ;

    always_comb begin
        occ_next  = occ;
        head_next = head;
        tail_next = tail;
        if (flush) begin
            occ_next  = OCC_EMPTY;
            head_next = EMPTY_ENTRY;
            tail_next = EMPTY_ENTRY;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        occ_next  = OCC_ONE;
                        head_next = incoming;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_next = incoming;
                    end else if (push) begin
                        occ_next  = OCC_FULL;
                        tail_next = incoming;
                    end else if (pop) begin
                        occ_next  = OCC_EMPTY;
                        head_next = EMPTY_ENTRY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        occ_next  = OCC_ONE;
                        head_next = tail;
                        tail_next = EMPTY_ENTRY;
                    end
                end
                default: begin
                    occ_next  = OCC_EMPTY;
                    head_next = EMPTY_ENTRY;
                    tail_next = EMPTY_ENTRY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ  <= OCC_EMPTY;
            head <= EMPTY_ENTRY;
            tail <= EMPTY_ENTRY;
        end else begin
            occ  <= occ_next;
            head <= head_next;
            tail <= tail_next;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - self-checking bench for if_id_buffer against a queue model
`timescale 1ns/1ps
module tb_if_id_buffer;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic [31:0] id_instr;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc[$];
    logic [31:0] m_instr[$];

    localparam logic [99:0] RESET_VIEW = {1'b0, 1'b1, 2'd0, 32'h0000_3000, 32'h0000_3008, 32'h0000_0000};

    logic [99:0] obs;
    assign obs = {id_valid, if_ready, count, id_pc, id_pc8, id_instr};

    if_id_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_ready (if_ready),
        .flush    (flush),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_pc8   (id_pc8),
        .id_instr (id_instr),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    function automatic logic [99:0] model_view();
        logic [31:0] hp;
        logic [31:0] hi;
        hp = 32'h0000_3000;
        hi = 32'h0000_0000;
        if (m_pc.size() > 0) begin
            hp = m_pc[0];
            hi = m_instr[0];
        end
        return {m_pc.size() != 0, m_pc.size() != 2, 2'(m_pc.size()), hp, hp + 32'd8, hi};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic idr);
        if_valid = v;
        if_pc    = pc;
        if_instr = $urandom;
        flush    = fl;
        id_ready = idr;
    endtask

    // One clock: the model applies the FIFO rules to the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (reset || flush) begin
            m_pc.delete();
            m_instr.delete();
        end else begin
            bit do_push;
            bit do_pop;
            do_push = if_valid && (m_pc.size() < 2);
            do_pop  = id_ready && (m_pc.size() > 0);
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_instr.pop_front());
            end
            if (do_push) begin
                m_pc.push_back(if_pc);
                m_instr.push_back(if_instr);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (obs !== RESET_VIEW) begin
            n_fail++;
            $display("FAIL reset_initial: got %h required %h", obs, RESET_VIEW);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h3000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3004, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (count !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_prefill_count: got %0d required 2", count);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== RESET_VIEW) begin
            n_fail++;
            $display("FAIL reset_async: got %h required %h", obs, RESET_VIEW);
        end
        m_pc.delete();
        m_instr.delete();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h3020, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (id_pc !== 32'h3020 || count !== 2'd1 || id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_push: got pc %h count %0d valid %b required pc 00003020 count 1 valid 1",
                     id_pc, count, id_valid);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            pc = 32'h3000 + 32'(4 * i);
            drive(1'b1, pc, 1'b0, 1'b1);
            tick();
            n_checks++;
            if (obs !== model_view() || id_pc !== pc || count !== 2'd1 || if_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream[%0d]: got %h required %h (pc %h)", i, obs, model_view(), pc);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (obs !== RESET_VIEW) begin
            n_fail++;
            $display("FAIL stream_empty: got %h required %h", obs, RESET_VIEW);
        end
    endtask

    task automatic test_stall_fill();
        drive(1'b1, 32'h3000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3004, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (count !== 2'd2 || if_ready !== 1'b0 || id_pc !== 32'h3000) begin
            n_fail++;
            $display("FAIL stall_full: got count %0d ready %b pc %h required 2 0 00003000", count, if_ready, id_pc);
        end
        drive(1'b1, 32'h3008, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (obs !== model_view() || id_pc !== 32'h3000 || count !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_hold: got %h required %h", obs, model_view());
        end
    endtask

    task automatic test_drain();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (id_pc !== 32'h3000 || id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_head0: got pc %h valid %b required 00003000 1", id_pc, id_valid);
        end
        tick();
        n_checks++;
        if (id_pc !== 32'h3004 || count !== 2'd1 || if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_head1: got pc %h count %0d ready %b required 00003004 1 1", id_pc, count, if_ready);
        end
        tick();
        n_checks++;
        if (obs !== RESET_VIEW || obs !== model_view()) begin
            n_fail++;
            $display("FAIL drain_empty: got %h required %h", obs, RESET_VIEW);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h3100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3104, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4000, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (obs !== RESET_VIEW) begin
            n_fail++;
            $display("FAIL flush_priority: got %h required %h", obs, RESET_VIEW);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (obs !== RESET_VIEW) begin
            n_fail++;
            $display("FAIL flush_dropped: got %h required %h", obs, RESET_VIEW);
        end
    endtask

    task automatic test_link_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (id_pc8 !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL link_wrap: got %h required 00000004", id_pc8);
        end
        drive(1'b1, 32'h3010, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (id_pc8 !== 32'h0000_3018 || id_pc !== 32'h3010 || count !== 2'd1) begin
            n_fail++;
            $display("FAIL link_3010: got pc8 %h pc %h count %0d required 00003018 00003010 1", id_pc8, id_pc, count);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic v;
            logic fl;
            logic idr;
            v   = ($urandom % 4) != 0;
            fl  = ($urandom % 20) == 0;
            idr = ($urandom % 3) == 0 ? 1'b0 : 1'b1;
            if ((i / 50) % 2 == 1) idr = ($urandom % 5) == 0;
            drive(v, $urandom & 32'hFFFF_FFFC, fl, idr);
            tick();
            n_checks++;
            if (obs !== model_view()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h", i, obs, model_view());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        if_valid = 1'b0;
        if_pc    = 32'h0;
        if_instr = 32'h0;
        flush    = 1'b0;
        id_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_drain();
        test_flush();
        test_link_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
